kpn_fire_scheduler: RTL and testbench
=====================================

# kpn_fire_scheduler

Firing-rule scheduler for a two-input Kahn Process Network actor (adder/subtractor node). Admits producer tokens into the two input FIFOs, pops both FIFOs only when each holds a token and the output channel has room, strobes the actor, and pushes its result downstream. Sits between the queue/FIFO front end and the arithmetic node, ahead of the BCD/display path, on the divided KPN clock.

## Interface
Parameters:
- COUNT_W, 16, width of the firing counter
- MAX_FIRINGS, 0, firings before `done` is raised; 0 means unlimited
- EXEC_CYCLES, 1, actor latency in cycles, range 1..15

Ports:
- clk  in  1  KPN clock; single clock domain
- rst_n  in  1  reset, synchronous, active-low
- run  in  1  level; 1 = free-running scheduling
- step  in  1  one-cycle pulse; requests exactly one firing while run=0
- src_req  in  2  producer i has a token to write
- src_grant  out  2  write enable into input FIFO i (the FIFO `wr`)
- in_empty  in  2  input FIFO i empty
- in_full  in  2  input FIFO i full
- out_full  in  1  downstream channel full
- rd  out  1  pop both input FIFOs (shared `rd`)
- fire  out  1  actor capture strobe
- wr  out  1  push actor result downstream
- fire_count  out  COUNT_W  completed firings
- busy  out  1  FSM not in IDLE/DONE
- done  out  1  MAX_FIRINGS reached; sticky

## Operation
- Grants (combinational): src_grant[i] = src_req[i] & ~in_full[i] & ~done. The channels are independent, so no arbitration is needed. Both can be granted in the same cycle.
- Enable: `en` = run | step_pending.
  - step_pending is set by `step` only in IDLE with run=0.
  - `step` is ignored when received in any other state.
  - step_pending is cleared on entry to READ.
- Firing rule: `ok` = ~in_empty[0] & ~in_empty[1] & ~out_full.
- FSM states and transitions:
  - IDLE: go to READ when en & ok; otherwise hold.
  - READ: rd=1 for exactly one cycle; go to EXEC.
  - EXEC: fire=1 on the first EXEC cycle only. Stay EXEC_CYCLES cycles using the down-counter; go to WRITE.
  - WRITE:
    - If ~out_full: wr=1 for one cycle and fire_count += 1. Then go to DONE if the new count equals MAX_FIRINGS (MAX_FIRINGS≠0), otherwise go to IDLE.
    - If out_full: hold with wr=0 (stall).
  - DONE: all strobes 0 and grants 0. Exit only via reset.
- Deasserting run mid-firing does not abort: the firing completes and the FSM then idles.
- fire_count arithmetic: unsigned, modulo 2^COUNT_W. With MAX_FIRINGS=0 it wraps from all-ones to 0 and `done` is never raised.
- `done` has priority over `run` and `step`.

## Timing
- Reset values (rst_n=0 at a clk edge): state IDLE; rd, fire, wr, busy, done = 0; fire_count = 0; step_pending = 0; exec counter = 0. src_grant follows its equation. FIFO contents are not touched.
- Reset mid-firing abandons the firing. A popped token is lost; this is by design.
- rd, fire, wr, busy and done are registered (Moore) outputs.
- Cycle n: IDLE samples en & ok. Then:
  - n+1: rd
  - n+2: fire (FIFO data is valid in this cycle)
  - n+1+EXEC_CYCLES+1: wr, if out_full=0
  - next firing can start its IDLE check one cycle after wr.
- Minimum firing period: 3+EXEC_CYCLES cycles.
- `ok` is sampled only in IDLE. out_full is re-checked in WRITE.
- rd is never asserted while either in_empty bit is 1 at the IDLE sample.
- `done` rises in the same cycle as the final wr.

## Structure
- Package `kpn_pkg`: FSM state enum (IDLE, READ, EXEC, WRITE, DONE) and the COUNT_W default constant, shared with future KPN controllers.
- Sub-module `kpn_exec_timer`: 4-bit loadable down-counter. Loads EXEC_CYCLES-1 on READ and flags `expired` at 0.

## Test plan
- Reset then run=1, src_req=2'b11, out_full=0, EXEC_CYCLES=1 → rd, fire and wr each pulse once every 4 cycles. fire_count reaches 5 after 20 cycles.
- in_empty=2'b01 held for 10 cycles with run=1 → rd never asserts. Clearing in_empty → rd fires 1 cycle after the IDLE sample.
- Hold out_full=1 during WRITE for 6 cycles → FSM stalls in WRITE with wr=0 and busy=1. wr pulses the cycle after out_full drops.
- run=0 with three `step` pulses, one given during EXEC → exactly 2 firings, fire_count=2.
- MAX_FIRINGS=3 → done=1 with the 3rd wr. Afterwards src_grant=0 and no rd, even with run=1. rst_n=0 clears done and fire_count.
- COUNT_W=4, MAX_FIRINGS=0, 17 firings → fire_count wraps from 15 to 0 and reads 1; done stays 0. Reset asserted during EXEC → outputs return to reset values on the next edge.

Source files
------------

// File: rtl/kpn_pkg.sv
// kpn_pkg: shared types and constants for KPN sequencing controllers.
//   kpn_state_e  - firing-scheduler FSM states
//   KPN_COUNT_W  - default width of firing counters
package kpn_pkg;

  localparam int KPN_COUNT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } kpn_state_e;

endpackage

// File: rtl/kpn_fire_scheduler_if.sv
// kpn_fire_scheduler_if: token handshake between the scheduler, the two
// input FIFOs, the producers and the downstream channel.
//   src_req   producer i has a token          (env -> sched)
//   src_grant write enable into input FIFO i  (sched -> env)
//   in_empty  input FIFO i empty              (env -> sched)
//   in_full   input FIFO i full               (env -> sched)
//   out_full  downstream channel full         (env -> sched)
//   rd        pop both input FIFOs            (sched -> env)
//   fire      actor capture strobe            (sched -> env)
//   wr        push actor result downstream    (sched -> env)
interface kpn_fire_scheduler_if;
  logic [1:0] src_req;
  logic [1:0] src_grant;
  logic [1:0] in_empty;
  logic [1:0] in_full;
  logic       out_full;
  logic       rd;
  logic       fire;
  logic       wr;

  modport master (
    input  src_req, in_empty, in_full, out_full,
    output src_grant, rd, fire, wr
  );

  modport slave (
    output src_req, in_empty, in_full, out_full,
    input  src_grant, rd, fire, wr
  );
endinterface

// File: rtl/kpn_exec_timer.sv
// kpn_exec_timer: 4-bit loadable down-counter timing the actor latency.
//   clk, rst_n  clock, synchronous active-low reset
//   load        load load_val this cycle
//   load_val    value loaded (latency - 1)
//   expired     counter is at 0
module kpn_exec_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic       expired
);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == 4'd0);

endmodule

// File: rtl/kpn_fire_scheduler.sv
// kpn_fire_scheduler: firing-rule scheduler for a two-input KPN actor.
//   clk, rst_n   KPN clock, synchronous active-low reset
//   run          level, free-running scheduling
//   step         one-cycle pulse, single firing while run=0
//   bus          token handshake (grants, FIFO status, rd/fire/wr)
//   fire_count   completed firings (wraps)
//   busy         FSM in READ/EXEC/WRITE
//   done         MAX_FIRINGS reached, sticky until reset
//
// state | meaning
// IDLE  | wait for enable and firing rule
// READ  | pop both input FIFOs
// EXEC  | actor running, fire on first cycle
// WRITE | push result; stalls while out_full
// DONE  | firing limit reached, everything quiet
module kpn_fire_scheduler
  import kpn_pkg::*;
#(
  parameter int COUNT_W     = KPN_COUNT_W,
  parameter int MAX_FIRINGS = 0,
  parameter int EXEC_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  input  logic                step,
  kpn_fire_scheduler_if.master bus,
  output logic [COUNT_W-1:0]  fire_count,
  output logic                busy,
  output logic                done
);

  localparam logic [COUNT_W-1:0] MAX_C     = COUNT_W'(MAX_FIRINGS);
  localparam logic [3:0]         EXEC_LOAD = 4'(EXEC_CYCLES - 1);

  kpn_state_e         state_q, state_d;
  logic               rd_q, rd_d, fire_q, fire_d, wr_q, wr_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic               step_pend_q, step_pend_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic               ok, timer_load, expired, commit;

  kpn_exec_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (EXEC_LOAD),
    .expired  (expired)
  );

  assign ok = ~bus.in_empty[0] & ~bus.in_empty[1] & ~bus.out_full;

  // wr is a registered strobe, so out_full is sampled the cycle before
  // the push: at the last EXEC cycle and at every stalled WRITE cycle.
  assign commit = ~bus.out_full &
                  (((state_q == ST_EXEC) & expired) |
                   ((state_q == ST_WRITE) & ~wr_q));

  always_comb begin
    state_d     = state_q;
    rd_d        = 1'b0;
    fire_d      = 1'b0;
    wr_d        = 1'b0;
    cnt_d       = cnt_q;
    done_d      = done_q;
    step_pend_d = step_pend_q;
    timer_load  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (step && !run) step_pend_d = 1'b1;
        if ((run || step_pend_q) && ok) begin
          state_d     = ST_READ;
          rd_d        = 1'b1;
          step_pend_d = 1'b0;
        end
      end
      ST_READ: begin
        state_d    = ST_EXEC;
        fire_d     = 1'b1;
        timer_load = 1'b1;
      end
      ST_EXEC: begin
        if (expired) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        if (wr_q) state_d = done_q ? ST_DONE : ST_IDLE;
      end
      default: state_d = ST_DONE;
    endcase

    if (commit) begin
      wr_d  = 1'b1;
      cnt_d = cnt_q + 1'b1;
      if ((MAX_FIRINGS != 0) && (cnt_d == MAX_C)) done_d = 1'b1;
    end
  end

  assign busy_d = (state_d == ST_READ) || (state_d == ST_EXEC) ||
                  (state_d == ST_WRITE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rd_q        <= 1'b0;
      fire_q      <= 1'b0;
      wr_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      step_pend_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      rd_q        <= rd_d;
      fire_q      <= fire_d;
      wr_q        <= wr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      step_pend_q <= step_pend_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.src_grant = bus.src_req & ~bus.in_full & {2{~done_q}};
  assign bus.rd        = rd_q;
  assign bus.fire      = fire_q;
  assign bus.wr        = wr_q;
  assign fire_count    = cnt_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_kpn_fire_scheduler.sv
module tb_kpn_fire_scheduler;

  logic clk;
  logic rst0_n, rst1_n, rst2_n;
  logic run0, run1, run2, step0, step1, step2;
  logic [1:0] src_req, in_empty, in_full;
  logic out_full;
  logic [15:0] fc0;
  logic [3:0]  fc1, fc2;
  logic busy0, busy1, busy2, done0, done1, done2;

  int n_chk, n_pass;
  int rd0_n, fire0_n, wr0_n, rd1_n, wr1_n;
  int stall_bad;

  kpn_fire_scheduler_if if0 ();
  kpn_fire_scheduler_if if1 ();
  kpn_fire_scheduler_if if2 ();

  assign if0.src_req = src_req;  assign if0.in_empty = in_empty;
  assign if0.in_full = in_full;  assign if0.out_full = out_full;
  assign if1.src_req = src_req;  assign if1.in_empty = in_empty;
  assign if1.in_full = in_full;  assign if1.out_full = out_full;
  assign if2.src_req = src_req;  assign if2.in_empty = in_empty;
  assign if2.in_full = in_full;  assign if2.out_full = out_full;

  kpn_fire_scheduler #(.COUNT_W(16), .MAX_FIRINGS(0), .EXEC_CYCLES(1)) u_dut0 (
    .clk(clk), .rst_n(rst0_n), .run(run0), .step(step0), .bus(if0),
    .fire_count(fc0), .busy(busy0), .done(done0));

  kpn_fire_scheduler #(.COUNT_W(4), .MAX_FIRINGS(3), .EXEC_CYCLES(2)) u_dut1 (
    .clk(clk), .rst_n(rst1_n), .run(run1), .step(step1), .bus(if1),
    .fire_count(fc1), .busy(busy1), .done(done1));

  kpn_fire_scheduler #(.COUNT_W(4), .MAX_FIRINGS(0), .EXEC_CYCLES(1)) u_dut2 (
    .clk(clk), .rst_n(rst2_n), .run(run2), .step(step2), .bus(if2),
    .fire_count(fc2), .busy(busy2), .done(done2));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    rd0_n   += int'(if0.rd);
    fire0_n += int'(if0.fire);
    wr0_n   += int'(if0.wr);
    rd1_n   += int'(if1.rd);
    wr1_n   += int'(if1.wr);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clk = 0; n_chk = 0; n_pass = 0;
    rd0_n = 0; fire0_n = 0; wr0_n = 0; rd1_n = 0; wr1_n = 0;
    rst0_n = 0; rst1_n = 0; rst2_n = 0;
    run0 = 0; run1 = 0; run2 = 0; step0 = 0; step1 = 0; step2 = 0;
    src_req = 2'b11; in_empty = 2'b11; in_full = 2'b00; out_full = 0;

    // reset values and grant equation
    tick(); tick();
    check("rst_outs", {if0.rd, if0.fire, if0.wr, busy0, done0}, 0);
    check("rst_count", fc0, 0);
    check("grant_both", if0.src_grant, 2'b11);
    in_full = 2'b01; #1;
    check("grant_full0", if0.src_grant, 2'b10);
    in_full = 2'b00;
    rst0_n = 1; rst1_n = 1; rst2_n = 1;

    // free-running, EXEC_CYCLES=1: period 4
    in_empty = 2'b00;
    rd0_n = 0; fire0_n = 0; wr0_n = 0;
    run0 = 1;
    tick();
    check("rd_latency", if0.rd, 1);
    repeat (19) tick();
    check("run_rd_cnt", rd0_n, 5);
    check("run_fire_cnt", fire0_n, 5);
    check("run_wr_cnt", wr0_n, 5);
    check("run_count", fc0, 5);
    run0 = 0;
    tick();
    check("idle_after_run", busy0, 0);

    // firing rule blocked by an empty FIFO
    in_empty = 2'b01; run0 = 1; rd0_n = 0;
    repeat (10) tick();
    check("no_rd_empty", rd0_n, 0);
    in_empty = 2'b00;
    tick();
    check("rd_after_fill", if0.rd, 1);
    tick(); tick();
    check("wr_after_fill", if0.wr, 1);
    run0 = 0;
    tick();
    check("count_after_fill", fc0, 6);

    // downstream stall in WRITE
    run0 = 1;
    tick();
    check("stall_rd", if0.rd, 1);
    out_full = 1; run0 = 0;
    tick();
    check("stall_fire", if0.fire, 1);
    tick();
    check("stall_enter", {if0.wr, busy0}, 2'b01);
    stall_bad = 0;
    repeat (5) begin
      tick();
      if (if0.wr || !busy0) stall_bad++;
    end
    check("stall_hold", stall_bad, 0);
    out_full = 0;
    tick();
    check("wr_after_release", if0.wr, 1);
    check("count_after_stall", fc0, 7);
    tick();
    check("idle_after_stall", {if0.wr, busy0}, 0);

    // stepping: three pulses, one during EXEC
    rd0_n = 0;
    step0 = 1; tick(); step0 = 0;
    tick(); tick();
    step0 = 1; tick(); step0 = 0;
    tick();
    step0 = 1; tick(); step0 = 0;
    repeat (8) tick();
    check("step_rd_cnt", rd0_n, 2);
    check("step_count", fc0, 9);

    // MAX_FIRINGS=3, EXEC_CYCLES=2: wr at ticks 4, 9, 14
    rd1_n = 0; wr1_n = 0;
    run1 = 1;
    repeat (13) tick();
    check("max_done_early", done1, 0);
    check("max_wr_cnt", wr1_n, 2);
    tick();
    check("max_done_with_wr", {if1.wr, done1}, 2'b11);
    check("max_count", fc1, 3);
    tick();
    check("max_done_state", {busy1, done1}, 2'b01);
    rd1_n = 0;
    repeat (10) tick();
    check("max_no_rd", rd1_n, 0);
    check("max_grant_off", if1.src_grant, 2'b00);
    rst1_n = 0;
    tick();
    check("max_rst_clear", {done1, fc1}, 0);
    rst1_n = 1; run1 = 0;
    tick();
    check("max_grant_back", if1.src_grant, 2'b11);

    // COUNT_W=4 wrap, MAX_FIRINGS=0
    run2 = 1;
    repeat (60) tick();
    check("wrap_15", fc2, 15);
    repeat (4) tick();
    check("wrap_0", fc2, 0);
    repeat (4) tick();
    check("wrap_1", fc2, 1);
    check("wrap_no_done", done2, 0);
    tick(); tick();
    check("wrap_exec", {if2.fire, busy2}, 2'b11);
    rst2_n = 0;
    tick();
    check("rst_mid_outs", {if2.rd, if2.fire, if2.wr, busy2, done2}, 0);
    check("rst_mid_count", fc2, 0);
    rst2_n = 1; run2 = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
